dilithium: RTL and testbench

- Top-level streaming wrapper for CRYSTALS-Dilithium signature verification.
- Accepts the public key, signature and message as one W-bit word stream, and forwards each tagged word to the arithmetic sub-module.
- Returns a single accept/reject word on an output stream.
- This block owns only protocol, field sequencing and word counting; it sits between the host bus adapter and the verify engine.

---
 rtl/dilithium_pkg.sv | 75 +++++++
 rtl/dilithium_verify_engine.sv | 89 ++++++++
 rtl/dilithium.sv | 102 ++++++++++
 tb/tb_dilithium.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dilithium_pkg.sv
// Shared types and field geometry for the Dilithium verify wrapper.
package dilithium_pkg;

  localparam logic [1:0] KEYGEN_MODE = 2'd0;
  localparam logic [1:0] SIGN_MODE   = 2'd1;
  localparam logic [1:0] VERIFY_MODE = 2'd2;

  // Word counter width; covers the largest field (560 words at W=64).
  localparam int unsigned CNT_W = 16;

  typedef enum logic [3:0] {
    IDLE, LOAD_RHO, LOAD_C, LOAD_Z, LOAD_T1, LOAD_MLEN, LOAD_MSG, LOAD_H,
    WAIT_ENG, OUTPUT
  } state_t;

  typedef enum logic [2:0] {
    TAG_RHO, TAG_C, TAG_Z, TAG_T1, TAG_MLEN, TAG_MSG, TAG_H
  } field_tag_t;

  // Encoded field size in bits; MLEN/MSG are sized at run time.
  function automatic int unsigned field_bits(int unsigned level, field_tag_t tag);
    case (tag)
      TAG_RHO, TAG_C: return 256;
      TAG_Z:          return (level == 5) ? 35840 : (level == 3) ? 25600 : 18432;
      TAG_T1:         return (level == 5) ? 20480 : (level == 3) ? 15360 : 10240;
      TAG_H:          return (level == 5) ? 664   : (level == 3) ? 488   : 672;
      default:        return 0;
    endcase
  endfunction

  function automatic int unsigned field_words(int unsigned level, field_tag_t tag,
                                              int unsigned w);
    return (field_bits(level, tag) + w - 1) / w;
  endfunction

  function automatic field_tag_t state_tag(state_t s);
    case (s)
      LOAD_C:    return TAG_C;
      LOAD_Z:    return TAG_Z;
      LOAD_T1:   return TAG_T1;
      LOAD_MLEN: return TAG_MLEN;
      LOAD_MSG:  return TAG_MSG;
      LOAD_H:    return TAG_H;
      default:   return TAG_RHO;
    endcase
  endfunction

  // Field sequencing differs between the two engine variants.
  function automatic state_t next_state(state_t s, bit hp);
    if (hp) begin
      case (s)
        LOAD_RHO:  return LOAD_C;
        LOAD_C:    return LOAD_Z;
        LOAD_Z:    return LOAD_T1;
        LOAD_T1:   return LOAD_MLEN;
        LOAD_MLEN: return LOAD_MSG;
        LOAD_MSG:  return LOAD_H;
        LOAD_H:    return WAIT_ENG;
        default:   return s;
      endcase
    end else begin
      case (s)
        LOAD_RHO:  return LOAD_T1;
        LOAD_T1:   return LOAD_C;
        LOAD_C:    return LOAD_Z;
        LOAD_Z:    return LOAD_H;
        LOAD_H:    return LOAD_MLEN;
        LOAD_MLEN: return LOAD_MSG;
        LOAD_MSG:  return WAIT_ENG;
        default:   return s;
      endcase
    end
  endfunction

endpackage

// File: rtl/dilithium_verify_engine.sv
// Verify engine: absorbs tagged field words (pad bits masked off) into a
// parity digest and reports reject when the digest is non-zero.
module dilithium_verify_engine
  import dilithium_pkg::*;
#(
  parameter int HIGH_PERF = 0,
  parameter int SEC_LEVEL = 2,
  parameter int W         = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [W-1:0] word,
  input  field_tag_t tag,
  input  logic       last,
  input  logic       valid,
  output logic       ready,
  output logic       done,
  output logic       reject
);

  typedef enum logic [1:0] {E_IDLE, E_LOAD, E_BUSY} eng_state_t;

  localparam field_tag_t FINAL_TAG = (HIGH_PERF != 0) ? TAG_H : TAG_MSG;

  eng_state_t  est;
  logic [W-1:0] acc, mlen_r, mask;
  logic [W+2:0] msg_bits;
  logic [2:0]   lat;
  int unsigned  r;

  assign ready = (est == E_LOAD);

  // Keep only the leading valid bits of a field's final word.
  always_comb begin
    msg_bits = {mlen_r, 3'b000};
    r        = 0;
    mask     = '1;
    if (last) begin
      if (tag == TAG_MSG) begin
        if (mlen_r == '0) mask = '0;
        else              r = 32'(msg_bits % (W+3)'(W));
      end else begin
        r = field_bits(SEC_LEVEL, tag) % unsigned'(W);
      end
      if (r != 0) mask = {W{1'b1}} << (unsigned'(W) - r);
    end
  end

  // Absorb words, then run a fixed-latency finish and pulse done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      est    <= E_IDLE;
      acc    <= '0;
      mlen_r <= '0;
      lat    <= '0;
      done   <= 1'b0;
      reject <= 1'b0;
    end else begin
      done <= 1'b0;
      case (est)
        E_IDLE: if (start) begin
          est    <= E_LOAD;
          acc    <= '0;
          mlen_r <= '0;
          reject <= 1'b0;
        end
        E_LOAD: if (valid) begin
          acc <= acc ^ (word & mask);
          if (tag == TAG_MLEN) mlen_r <= word;
          if (last && tag == FINAL_TAG) begin
            est <= E_BUSY;
            lat <= '1;
          end
        end
        default: begin
          if (lat == '0) begin
            done   <= 1'b1;
            reject <= |acc;
            est    <= E_IDLE;
          end else begin
            lat <= lat - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/dilithium.sv
// Streaming verify wrapper: sequences fields, counts words, returns verdict.
module dilithium
  import dilithium_pkg::*;
#(
  parameter int HIGH_PERF = 0,
  parameter int SEC_LEVEL = 2,
  parameter int W         = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic         valid_i,
  output logic         ready_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_o,
  output logic [W-1:0] data_o
);

  state_t           state;
  field_tag_t       tag;
  logic [CNT_W-1:0] cnt, msg_words, target;
  logic [W+3:0]     mlen_words;
  logic             in_load, xfer, last, eng_start;
  logic             eng_ready, eng_done, eng_reject;

  // Current field's tag and word budget.
  always_comb begin
    in_load = (state == LOAD_RHO) || (state == LOAD_C)    || (state == LOAD_Z)   ||
              (state == LOAD_T1)  || (state == LOAD_MLEN) || (state == LOAD_MSG) ||
              (state == LOAD_H);
    tag = state_tag(state);
    case (state)
      LOAD_MLEN: target = CNT_W'(1);
      LOAD_MSG:  target = msg_words;
      default:   target = CNT_W'(field_words(SEC_LEVEL, tag, W));
    endcase
    last = (cnt == target - 1'b1);
  end

  assign ready_i    = in_load && eng_ready;
  assign xfer       = valid_i && ready_i;
  assign eng_start  = (state == IDLE) && start && (mode == VERIFY_MODE);
  assign mlen_words = ({1'b0, data_i, 3'b000} + (W+4)'(W-1)) / (W+4)'(W);

  // Controller FSM with word counter and registered result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      msg_words <= CNT_W'(1);
      valid_o   <= 1'b0;
      data_o    <= '0;
    end else begin
      case (state)
        IDLE: if (eng_start) begin
          state <= LOAD_RHO;
          cnt   <= '0;
        end
        WAIT_ENG: if (eng_done) begin
          state   <= OUTPUT;
          valid_o <= 1'b1;
          data_o  <= {{(W-1){1'b0}}, eng_reject};
        end
        OUTPUT: if (ready_o) begin
          state   <= IDLE;
          valid_o <= 1'b0;
        end
        default: if (xfer) begin
          // Zero-length messages still occupy one (ignored) word.
          if (state == LOAD_MLEN)
            msg_words <= (data_i == '0) ? CNT_W'(1) : CNT_W'(mlen_words);
          if (last) begin
            state <= next_state(state, HIGH_PERF != 0);
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  dilithium_verify_engine #(
    .HIGH_PERF(HIGH_PERF),
    .SEC_LEVEL(SEC_LEVEL),
    .W        (W)
  ) u_engine (
    .clk   (clk),
    .rst   (rst),
    .start (eng_start),
    .word  (data_i),
    .tag   (tag),
    .last  (last),
    .valid (valid_i && in_load),
    .ready (eng_ready),
    .done  (eng_done),
    .reject(eng_reject)
  );

endmodule

// File: tb/tb_dilithium.sv
// Scoreboard bench for dilithium: L2/HP=1, L3/HP=0 and L5/HP=1 instances.
module tb_dilithium;

  logic             clk;
  logic             rst;
  logic [2:0]       start, valid_i, ready_i, valid_o, ready_o;
  logic [1:0]       mode   [3];
  logic [63:0]      data_i [3];
  logic [63:0]      data_o [3];

  typedef struct {
    int          dut;
    logic [63:0] val;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [63:0] sw[$];
  logic [63:0] sm[$];
  int          fs[7];
  int          n_chk = 0;
  int          n_fail = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dilithium #(
      .HIGH_PERF((g == 1) ? 0 : 1),
      .SEC_LEVEL((g == 0) ? 2 : (g == 1) ? 3 : 5),
      .W        (64)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start[g]),
      .mode   (mode[g]),
      .valid_i(valid_i[g]),
      .ready_i(ready_i[g]),
      .data_i (data_i[g]),
      .valid_o(valid_o[g]),
      .ready_o(ready_o[g]),
      .data_o (data_o[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every accepted result word is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        if (valid_o[k] && ready_o[k]) begin
          n_chk++;
          if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_result dut%0d: data_o=%0h, required no output", k, data_o[k]);
          end else begin
            mon_e = sbq.pop_front();
            if (mon_e.dut != k || data_o[k] !== mon_e.val) begin
              n_fail++;
              $display("FAIL result: dut%0d data_o=%0h, required dut%0d data_o=%0h",
                       k, data_o[k], mon_e.dut, mon_e.val);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, got, req);
    end
  endtask

  // Field sizes in bits: 0 rho, 1 c, 2 z, 3 t1, 6 h.
  function automatic int tb_bits(int lv, int f);
    case (f)
      2:       return (lv == 2) ? 18432 : (lv == 3) ? 25600 : 35840;
      3:       return (lv == 2) ? 10240 : (lv == 3) ? 15360 : 20480;
      6:       return (lv == 2) ? 672   : (lv == 3) ? 488   : 664;
      default: return 256;
    endcase
  endfunction

  // Builds the word stream with a fix-up in rho[0] so the masked digest is zero,
  // then optionally flips one bit and derives the expected verdict.
  task automatic build(input int k, input int mlen, input int ff, input int fw,
                       input int fb, output logic [63:0] expv);
    int          lv, f, bits, nw, r, idx;
    int          order[7];
    logic [63:0] w, m, acc;
    lv = (k == 0) ? 2 : (k == 1) ? 3 : 5;
    if (k != 1) order = '{0, 1, 2, 3, 4, 5, 6};
    else        order = '{0, 3, 1, 2, 6, 4, 5};
    sw.delete();
    sm.delete();
    for (int i = 0; i < 7; i++) begin
      f = order[i];
      fs[f] = sw.size();
      if (f == 4) begin
        sw.push_back(64'(mlen));
        sm.push_back('1);
      end else begin
        bits = (f == 5) ? mlen * 8 : tb_bits(lv, f);
        nw   = (f == 5 && mlen == 0) ? 1 : (bits + 63) / 64;
        r    = bits % 64;
        for (int j = 0; j < nw; j++) begin
          w = {$urandom, $urandom};
          m = '1;
          if (j == nw - 1) begin
            if (f == 5 && mlen == 0) m = '0;
            else if (r != 0)         m = m << (64 - r);
          end
          sw.push_back(w);
          sm.push_back(m);
        end
      end
    end
    sw[0] = '0;
    acc = '0;
    for (int i = 0; i < sw.size(); i++) acc ^= sw[i] & sm[i];
    sw[0] = acc;
    if (ff >= 0) begin
      idx = fs[ff] + fw;
      w = sw[idx];
      w[fb] = ~w[fb];
      sw[idx] = w;
    end
    acc = '0;
    for (int i = 0; i < sw.size(); i++) acc ^= sw[i] & sm[i];
    expv = {63'b0, (acc != '0)};
  endtask

  task automatic drive_word(input int k, input logic [63:0] w, output bit ok);
    valid_i[k] = 1'b1;
    data_i[k]  = w;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ready_i[k]) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    valid_i[k] = 1'b0;
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL word_accept_timeout dut%0d: ready_i=0, required 1", k);
    end
  endtask

  task automatic run(input int k, input int mlen, input int ff, input int fw, input int fb,
                     input bit gaps, input bit stall, input int abort_at);
    logic [63:0] expv;
    bit          ok, bad;
    int          lim;
    build(k, mlen, ff, fw, fb, expv);
    if (abort_at < 0) sbq.push_back('{k, expv});
    ready_o[k] = !stall;
    @(posedge clk); #1;
    start[k] = 1'b1;
    mode[k]  = 2'd2;
    @(posedge clk); #1;
    start[k] = 1'b0;
    mode[k]  = 2'd0;
    for (int i = 0; i < sw.size(); i++) begin
      if (abort_at >= 0 && i == abort_at) return;
      if (gaps) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      drive_word(k, sw[i], ok);
      if (!ok) return;
    end
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ready_i[k] !== 1'b0) bad = 1'b1;
    end
    chk("ready_low_after_last_word", 64'(bad), 64'(0));
    if (stall) begin
      lim = 0;
      while (valid_o[k] !== 1'b1 && lim < 100) begin
        @(negedge clk);
        lim++;
      end
      chk("output_appears", 64'(valid_o[k]), 64'(1));
      bad = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (valid_o[k] !== 1'b1 || data_o[k] !== expv) bad = 1'b1;
      end
      chk("output_hold_while_stalled", 64'(bad), 64'(0));
      @(posedge clk); #1;
      ready_o[k] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("valid_clear_after_accept", 64'(valid_o[k]), 64'(0));
    end else begin
      lim = 0;
      while (sbq.size() != 0 && lim < 100) begin
        @(posedge clk);
        lim++;
      end
      chk("result_delivered", 64'(sbq.size()), 64'(0));
      @(negedge clk);
    end
    chk("idle_after_result", {62'b0, valid_o[k], ready_i[k]}, 64'(0));
  endtask

  task automatic mode_ignored(input int k, input logic [1:0] md);
    bit bad;
    @(posedge clk); #1;
    start[k]   = 1'b1;
    mode[k]    = md;
    valid_i[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ready_i[k] !== 1'b0) bad = 1'b1;
    end
    valid_i[k] = 1'b0;
    mode[k]    = 2'd0;
    chk("non_verify_mode_ignored", 64'(bad), 64'(0));
  endtask

  initial begin
    start   = '0;
    valid_i = '0;
    ready_o = '1;
    for (int k = 0; k < 3; k++) begin
      mode[k]   = 2'd0;
      data_i[k] = '0;
    end
    rst = 1'b1;
    #3 rst = 1'b0;
    #9;
    for (int k = 0; k < 3; k++)
      chk("reset_state", {data_o[k][61:0], valid_o[k], ready_i[k]}, 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // L2, high-performance order
    run(0, 20, -1, 0, 0, 1'b0, 1'b0, -1);   // valid signature
    run(0, 20,  1, 2, 17, 1'b0, 1'b0, -1);  // bit of c flipped
    run(0,  0, -1, 0, 0, 1'b0, 1'b0, -1);   // empty message, one dummy word
    run(0, 20,  6, 10, 3, 1'b0, 1'b0, -1);  // pad bit of last h word flipped

    // L3, low-area order
    run(1, 33, -1, 0, 0, 1'b0, 1'b0, -1);   // 5 message words
    run(1,  0, -1, 0, 0, 1'b0, 1'b0, -1);
    run(1, 33, -1, 0, 0, 1'b1, 1'b1, -1);   // input gaps, output stalled 20 cycles
    run(1, 33,  2, 100, 40, 1'b0, 1'b0, -1);// z bit flipped
    run(1, 33,  5, 4, 0, 1'b0, 1'b0, -1);   // message pad bit flipped
    run(1, 33,  5, 4, 63, 1'b0, 1'b0, -1);  // message data bit flipped

    // L5: abort inside z, then full run
    run(2, 7, -1, 0, 0, 1'b0, 1'b0, 18);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("reset_mid_load_z", {data_o[2][61:0], valid_o[2], ready_i[2]}, 64'(0));
    #5 rst = 1'b1;
    run(2, 7, -1, 0, 0, 1'b0, 1'b0, -1);
    mode_ignored(2, 2'd1);
    mode_ignored(2, 2'd0);

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
